// File: rtl/insn_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : insn_dispatch_pkg
// Description : Shared types for the dispatch stage: RV32I major opcodes,
//               ROB operation classes, the canonical NOP and the decode
//               result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package insn_dispatch_pkg;

   // RV32I major opcodes (insn[6:0])
   typedef enum logic [6:0] {
      OPCODE_LOAD     = 7'b0000011,
      OPCODE_MISC_MEM = 7'b0001111,
      OPCODE_OPIMM    = 7'b0010011,
      OPCODE_AUIPC    = 7'b0010111,
      OPCODE_STORE    = 7'b0100011,
      OPCODE_OP       = 7'b0110011,
      OPCODE_LUI      = 7'b0110111,
      OPCODE_BRANCH   = 7'b1100011,
      OPCODE_JALR     = 7'b1100111,
      OPCODE_JAL      = 7'b1101111,
      OPCODE_SYSTEM   = 7'b1110011
   } opcode_t;

   // Operation class recorded in the reorder buffer
   typedef enum logic [1:0] {
      ROB_OP_INT = 2'd0,
      ROB_OP_BR  = 2'd1,
      ROB_OP_LD  = 2'd2,
      ROB_OP_ST  = 2'd3
   } rob_op_t;

   // addi x0,x0,0 - the canonical NOP
   localparam logic [31:0] c_NOOP = 32'h00000013;

   // Result of decoding one instruction's major opcode
   typedef struct packed {
      opcode_t opcode;     // opcode forwarded to the RS (NOP's for unknowns)
      rob_op_t rob_op;     // ROB operation class
      logic    rd_valid;   // instruction writes insn[11:7]
      logic    src0_used;  // rs1 is read
      logic    src1_used;  // rs2 is read
      logic    rs_bound;   // needs a reservation-station slot
   } decode_t;

endpackage : insn_dispatch_pkg
`default_nettype wire

// File: rtl/insn_decode.sv
`default_nettype none
// ============================================================================
// Module      : insn_decode
// Description : Maps an RV32I major opcode to its ROB class, destination
//               validity, source-usage flags and RS routing. Anything that is
//               not an execution opcode is handled as a ROB-only entry.
// Revision    : 1.0 - initial release
// ============================================================================
module insn_decode
   import insn_dispatch_pkg::*;
(
   input  logic [6:0] i_opcode,
   output decode_t    o_dec
);

   localparam logic [6:0] c_NOP_OPCODE = c_NOOP[6:0];

   // Opcode classification; unknown opcodes fall through as a ROB-only NOP
   always_comb begin
      o_dec           = '0;
      o_dec.opcode    = opcode_t'(c_NOP_OPCODE);
      o_dec.rob_op    = ROB_OP_INT;
      case (i_opcode)
         OPCODE_OPIMM: begin
            o_dec.opcode    = OPCODE_OPIMM;
            o_dec.rd_valid  = 1'b1;
            o_dec.src0_used = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_OP: begin
            o_dec.opcode    = OPCODE_OP;
            o_dec.rd_valid  = 1'b1;
            o_dec.src0_used = 1'b1;
            o_dec.src1_used = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_LUI: begin
            o_dec.opcode    = OPCODE_LUI;
            o_dec.rd_valid  = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_AUIPC: begin
            o_dec.opcode    = OPCODE_AUIPC;
            o_dec.rd_valid  = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_JAL: begin
            o_dec.opcode    = OPCODE_JAL;
            o_dec.rob_op    = ROB_OP_BR;
            o_dec.rd_valid  = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_JALR: begin
            o_dec.opcode    = OPCODE_JALR;
            o_dec.rob_op    = ROB_OP_BR;
            o_dec.rd_valid  = 1'b1;
            o_dec.src0_used = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_BRANCH: begin
            o_dec.opcode    = OPCODE_BRANCH;
            o_dec.rob_op    = ROB_OP_BR;
            o_dec.src0_used = 1'b1;
            o_dec.src1_used = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_LOAD: begin
            o_dec.opcode    = OPCODE_LOAD;
            o_dec.rob_op    = ROB_OP_LD;
            o_dec.rd_valid  = 1'b1;
            o_dec.src0_used = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_STORE: begin
            o_dec.opcode    = OPCODE_STORE;
            o_dec.rob_op    = ROB_OP_ST;
            o_dec.src0_used = 1'b1;
            o_dec.src1_used = 1'b1;
            o_dec.rs_bound  = 1'b1;
         end
         OPCODE_MISC_MEM: o_dec.opcode = OPCODE_MISC_MEM;
         OPCODE_SYSTEM:   o_dec.opcode = OPCODE_SYSTEM;
         default:         o_dec.opcode = opcode_t'(c_NOP_OPCODE);
      endcase
   end

endmodule : insn_decode
`default_nettype wire

// File: rtl/insn_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : insn_dispatch
// Description : Single-issue in-order dispatch. Pops the instruction FIFO
//               head, decodes it, resolves operands through the ROB lookup
//               port and writes one ROB entry plus (when execution is needed)
//               one RS slot in the same cycle. Zero latency.
//               Optional macro DISPATCH_COUNT_EN adds o_dispatch_count, a
//               free-running count of dispatched instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module insn_dispatch
   import insn_dispatch_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int TAG_WIDTH      = 6
) (
   input  logic                          clk,
   input  logic                          n_rst,
   // instruction FIFO
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_fifo_data,
   input  logic                          i_fifo_empty,
   output logic                          o_fifo_rd_en,
   // reorder buffer
   input  logic                          i_rob_stall,
   input  logic [TAG_WIDTH-1:0]          i_rob_tag,
   output logic                          o_rob_en,
   output logic                          o_rob_rdy,
   output rob_op_t                       o_rob_op,
   output logic [ADDR_WIDTH-1:0]         o_rob_iaddr,
   output logic [ADDR_WIDTH-1:0]         o_rob_addr,
   output logic [DATA_WIDTH-1:0]         o_rob_data,
   output logic [REG_ADDR_WIDTH-1:0]     o_rob_rdest,
   // ROB operand lookup
   output logic [REG_ADDR_WIDTH-1:0]     o_lookup_rsrc [2],
   input  logic                          i_lookup_rdy  [2],
   input  logic [DATA_WIDTH-1:0]         i_lookup_data [2],
   input  logic [TAG_WIDTH-1:0]          i_lookup_tag  [2],
   // reservation station
   input  logic                          i_rs_stall,
   output logic                          o_rs_en,
   output opcode_t                       o_rs_opcode,
   output logic [ADDR_WIDTH-1:0]         o_rs_iaddr,
   output logic [DATA_WIDTH-1:0]         o_rs_insn,
   output logic                          o_rs_src_rdy  [2],
   output logic [DATA_WIDTH-1:0]         o_rs_src_data [2],
   output logic [TAG_WIDTH-1:0]          o_rs_src_tag  [2],
   output logic [TAG_WIDTH-1:0]          o_rs_dst_tag
`ifdef DISPATCH_COUNT_EN
   ,
   output logic [31:0]                   o_dispatch_count
`endif
);

   logic [DATA_WIDTH-1:0]     w_insn;
   logic [ADDR_WIDTH-1:0]     w_pc;
   logic                      w_go;
   decode_t                   w_dec;
   logic [REG_ADDR_WIDTH-1:0] w_src_idx  [2];
   logic                      w_src_used [2];

   assign w_insn = i_fifo_data[DATA_WIDTH-1:0];
   assign w_pc   = i_fifo_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

   // Any stall blocks dispatch, even for ROB-only entries, so the ROB and RS
   // always advance together.
   assign w_go = n_rst & ~i_fifo_empty & ~i_rob_stall & ~i_rs_stall;

   assign w_src_idx[0]  = w_insn[19:15];
   assign w_src_idx[1]  = w_insn[24:20];
   assign w_src_used[0] = w_dec.src0_used;
   assign w_src_used[1] = w_dec.src1_used;

   insn_decode u_decode (
      .i_opcode (w_insn[6:0]),
      .o_dec    (w_dec)
   );

   // Dispatch outputs: all zero while in reset, otherwise decoded from the head
   always_comb begin
      o_fifo_rd_en = 1'b0;
      o_rob_en     = 1'b0;
      o_rob_rdy    = 1'b0;
      o_rob_op     = ROB_OP_INT;
      o_rob_iaddr  = '0;
      o_rob_addr   = '0;
      o_rob_data   = '0;
      o_rob_rdest  = '0;
      o_rs_en      = 1'b0;
      o_rs_opcode  = opcode_t'(7'd0);
      o_rs_iaddr   = '0;
      o_rs_insn    = '0;
      o_rs_dst_tag = '0;
      for (int i = 0; i < 2; i++) begin
         o_lookup_rsrc[i] = '0;
         o_rs_src_rdy[i]  = 1'b0;
         o_rs_src_data[i] = '0;
         o_rs_src_tag[i]  = '0;
      end
      if (n_rst) begin
         o_fifo_rd_en = w_go;
         o_rob_en     = w_go;
         o_rs_en      = w_go & w_dec.rs_bound;
         o_rob_rdy    = ~w_dec.rs_bound;
         o_rob_op     = w_dec.rob_op;
         o_rob_iaddr  = w_pc;
         o_rob_rdest  = w_dec.rd_valid ? w_insn[11:7] : '0;
         o_rs_opcode  = w_dec.opcode;
         o_rs_iaddr   = w_pc;
         o_rs_insn    = w_insn;
         o_rs_dst_tag = i_rob_tag;
         for (int i = 0; i < 2; i++) begin
            o_lookup_rsrc[i] = w_src_idx[i];
            // x0 and unread sources never wait on a producer
            if (!w_src_used[i] || (w_src_idx[i] == '0)) begin
               o_rs_src_rdy[i]  = 1'b1;
               o_rs_src_data[i] = '0;
               o_rs_src_tag[i]  = '0;
            end else begin
               o_rs_src_rdy[i]  = i_lookup_rdy[i];
               o_rs_src_data[i] = i_lookup_data[i];
               o_rs_src_tag[i]  = i_lookup_tag[i];
            end
         end
      end
   end

`ifdef DISPATCH_COUNT_EN
   logic [31:0] r_dispatch_count;

   // Count dispatched instructions, wrapping naturally at 2^32
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_dispatch_count <= '0;
      end else if (w_go) begin
         r_dispatch_count <= r_dispatch_count + 32'd1;
      end
   end

   assign o_dispatch_count = r_dispatch_count;
`else
   logic w_unused_clk;
   assign w_unused_clk = clk;
`endif

endmodule : insn_dispatch
`default_nettype wire

// File: tb/tb_insn_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_insn_dispatch
// Description : Self-checking bench for insn_dispatch: directed cases followed
//               by randomized heads, compared against a rule-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_dispatch;
   import insn_dispatch_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [63:0] fifo_data;
   logic        fifo_empty, fifo_rd_en;
   logic        rob_stall;
   logic [5:0]  rob_tag;
   logic        rob_en, rob_rdy;
   rob_op_t     rob_op;
   logic [31:0] rob_iaddr, rob_addr, rob_data;
   logic [4:0]  rob_rdest;
   logic [4:0]  lookup_rsrc [2];
   logic        lookup_rdy  [2];
   logic [31:0] lookup_data [2];
   logic [5:0]  lookup_tag  [2];
   logic        rs_stall, rs_en;
   opcode_t     rs_opcode;
   logic [31:0] rs_iaddr, rs_insn;
   logic        rs_src_rdy  [2];
   logic [31:0] rs_src_data [2];
   logic [5:0]  rs_src_tag  [2];
   logic [5:0]  rs_dst_tag;
`ifdef DISPATCH_COUNT_EN
   logic [31:0] dispatch_count;
   logic [31:0] exp_cnt;
   bit          cnt_known = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   insn_dispatch dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .i_fifo_data   (fifo_data),
      .i_fifo_empty  (fifo_empty),
      .o_fifo_rd_en  (fifo_rd_en),
      .i_rob_stall   (rob_stall),
      .i_rob_tag     (rob_tag),
      .o_rob_en      (rob_en),
      .o_rob_rdy     (rob_rdy),
      .o_rob_op      (rob_op),
      .o_rob_iaddr   (rob_iaddr),
      .o_rob_addr    (rob_addr),
      .o_rob_data    (rob_data),
      .o_rob_rdest   (rob_rdest),
      .o_lookup_rsrc (lookup_rsrc),
      .i_lookup_rdy  (lookup_rdy),
      .i_lookup_data (lookup_data),
      .i_lookup_tag  (lookup_tag),
      .i_rs_stall    (rs_stall),
      .o_rs_en       (rs_en),
      .o_rs_opcode   (rs_opcode),
      .o_rs_iaddr    (rs_iaddr),
      .o_rs_insn     (rs_insn),
      .o_rs_src_rdy  (rs_src_rdy),
      .o_rs_src_data (rs_src_data),
      .o_rs_src_tag  (rs_src_tag),
      .o_rs_dst_tag  (rs_dst_tag)
`ifdef DISPATCH_COUNT_EN
      ,
      .o_dispatch_count (dispatch_count)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check mid-low-phase, model the counter edge
   task automatic step(input logic rst, input logic empty, input logic robst,
                       input logic rsst, input logic [31:0] pc, input logic [31:0] insn,
                       input logic lr0, input logic lr1,
                       input logic [31:0] ld0, input logic [31:0] ld1,
                       input logic [5:0] lt0, input logic [5:0] lt1,
                       input logic [5:0] rtag);
      logic [6:0]  opc;
      logic [6:0]  nop_opc;
      logic [31:0] noop;
      bit          rs_bound, has_rd, use0, use1, go;
      logic [1:0]  e_op;
      logic [6:0]  e_opc;
      logic [4:0]  s0, s1;
      logic        e_rdy0, e_rdy1;
      logic [31:0] e_d0, e_d1;
      logic [5:0]  e_t0, e_t1;

      @(negedge clk);
      n_rst = rst; fifo_empty = empty; rob_stall = robst; rs_stall = rsst;
      fifo_data = {pc, insn}; rob_tag = rtag;
      lookup_rdy[0] = lr0; lookup_rdy[1] = lr1;
      lookup_data[0] = ld0; lookup_data[1] = ld1;
      lookup_tag[0] = lt0; lookup_tag[1] = lt1;
      #2;

      noop     = c_NOOP;
      nop_opc  = noop[6:0];
      opc      = insn[6:0];
      rs_bound = opc inside {7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
      has_rd   = opc inside {7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03};
      use0     = rs_bound && !(opc inside {7'h37, 7'h17, 7'h6F});
      use1     = opc inside {7'h33, 7'h63, 7'h23};
      e_op     = (opc == 7'h03) ? 2'd2 : (opc == 7'h23) ? 2'd3 :
                 (opc inside {7'h6F, 7'h67, 7'h63}) ? 2'd1 : 2'd0;
      e_opc    = (rs_bound || opc inside {7'h0F, 7'h73}) ? opc : nop_opc;
      go       = rst && !empty && !robst && !rsst;
      s0 = insn[19:15];
      s1 = insn[24:20];
      if (!use0 || s0 == 0) begin e_rdy0 = 1; e_d0 = 0; e_t0 = 0; end
      else begin e_rdy0 = lr0; e_d0 = ld0; e_t0 = lt0; end
      if (!use1 || s1 == 0) begin e_rdy1 = 1; e_d1 = 0; e_t1 = 0; end
      else begin e_rdy1 = lr1; e_d1 = ld1; e_t1 = lt1; end

      chk("fifo_rd_en", fifo_rd_en, go);
      chk("rob_en",     rob_en,     go);
      chk("rs_en",      rs_en,      go && rs_bound);
      chk("rob_addr",   rob_addr,   0);
      chk("rob_data",   rob_data,   0);
      if (!rst) begin
         chk("rst_rob_rdy",  rob_rdy,   0);
         chk("rst_rob_op",   rob_op,    0);
         chk("rst_rob_iaddr",rob_iaddr, 0);
         chk("rst_rdest",    rob_rdest, 0);
         chk("rst_rsrc0",    lookup_rsrc[0], 0);
         chk("rst_rsrc1",    lookup_rsrc[1], 0);
         chk("rst_rs_opc",   rs_opcode, 0);
         chk("rst_rs_insn",  rs_insn,   0);
         chk("rst_rs_iaddr", rs_iaddr,  0);
         chk("rst_src_rdy0", rs_src_rdy[0], 0);
         chk("rst_src_rdy1", rs_src_rdy[1], 0);
         chk("rst_src_d0",   rs_src_data[0], 0);
         chk("rst_src_t1",   rs_src_tag[1], 0);
         chk("rst_dst_tag",  rs_dst_tag, 0);
      end else begin
         chk("rob_rdy",   rob_rdy,   !rs_bound);
         chk("rob_op",    rob_op,    e_op);
         chk("rob_iaddr", rob_iaddr, pc);
         chk("rdest",     rob_rdest, has_rd ? insn[11:7] : 5'd0);
         chk("rsrc0",     lookup_rsrc[0], s0);
         chk("rsrc1",     lookup_rsrc[1], s1);
         chk("rs_opcode", rs_opcode, e_opc);
         chk("rs_iaddr",  rs_iaddr,  pc);
         chk("rs_insn",   rs_insn,   insn);
         chk("src_rdy0",  rs_src_rdy[0],  e_rdy0);
         chk("src_rdy1",  rs_src_rdy[1],  e_rdy1);
         chk("src_data0", rs_src_data[0], e_d0);
         chk("src_data1", rs_src_data[1], e_d1);
         chk("src_tag0",  rs_src_tag[0],  e_t0);
         chk("src_tag1",  rs_src_tag[1],  e_t1);
         chk("dst_tag",   rs_dst_tag,     rtag);
      end
`ifdef DISPATCH_COUNT_EN
      if (cnt_known) chk("dispatch_count", dispatch_count, exp_cnt);
      if (!rst) begin exp_cnt = 0; cnt_known = 1'b1; end
      else if (go) exp_cnt = exp_cnt + 1;
`endif
   endtask

   logic [6:0] opc_pool [14] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h0F, 7'h73, 7'h00, 7'h7F, 7'h2B};

   initial begin
      n_rst = 0; fifo_empty = 1; rob_stall = 0; rs_stall = 0; fifo_data = '0; rob_tag = 0;
      for (int i = 0; i < 2; i++) begin
         lookup_rdy[i] = 0; lookup_data[i] = 0; lookup_tag[i] = 0;
      end

      // reset with a valid head present
      step(0, 0, 0, 0, 32'h100, 32'h002081B3, 1, 1, 5, 7, 0, 0, 4);
      step(0, 0, 0, 0, 32'h100, 32'h002081B3, 1, 1, 5, 7, 0, 0, 4);
      // add x3,x1,x2 dispatches right after release
      step(1, 0, 0, 0, 32'h100, 32'h002081B3, 1, 1, 5, 7, 0, 0, 4);
      // lui x5,0x12345
      step(1, 0, 0, 0, 32'h104, 32'h123452B7, 0, 0, 32'hAA, 32'hBB, 3, 3, 5);
      // sw x2,0(x1) with rs2 still pending on tag 9
      step(1, 0, 0, 0, 32'h108, 32'h0020A023, 1, 0, 32'h11, 32'h22, 0, 9, 6);
      // fence: ROB-only
      step(1, 0, 0, 0, 32'h10C, 32'h0000000F, 1, 1, 1, 2, 0, 0, 7);
      // each blocking condition with a valid head
      step(1, 0, 1, 0, 32'h110, 32'h002081B3, 1, 1, 5, 7, 0, 0, 8);
      step(1, 0, 0, 1, 32'h110, 32'h002081B3, 1, 1, 5, 7, 0, 0, 8);
      step(1, 1, 0, 0, 32'h110, 32'h002081B3, 1, 1, 5, 7, 0, 0, 8);
      step(1, 0, 1, 1, 32'h110, 32'h0000000F, 1, 1, 5, 7, 0, 0, 8);
      // unknown opcode is a NOP, x0 sources forced ready
      step(1, 0, 0, 0, 32'h114, 32'h0000007F, 0, 0, 9, 9, 9, 9, 9);
      step(1, 0, 0, 0, 32'h118, 32'h00000033, 0, 0, 9, 9, 9, 9, 10);
      // reset mid-stream then resume
      step(0, 0, 0, 0, 32'h11C, 32'h00A00093, 1, 1, 3, 3, 0, 0, 11);
      step(1, 0, 0, 0, 32'h11C, 32'h00A00093, 1, 1, 3, 3, 0, 0, 11);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] insn;
         insn = $urandom;
         insn[6:0] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : opc_pool[$urandom_range(0, 13)];
         if ($urandom_range(0, 5) == 0) insn[19:15] = 0;
         if ($urandom_range(0, 5) == 0) insn[24:20] = 0;
         step($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom, insn, 1'($urandom), 1'($urandom), $urandom, $urandom,
              6'($urandom), 6'($urandom), 6'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_insn_dispatch
`default_nettype wire
